// File: rtl/core_bus_arb.sv
// core_bus_arb: two-master (ibus, dbus) to one-slave Wishbone B4 pipelined
// arbiter. Ownership is held per bus cycle and an outstanding-strobe counter
// keeps the grant until every accepted strobe has been acknowledged. This
// guarantees that acks always return to the master that issued them.
// Simultaneous requests are resolved round-robin against the last owner.
module core_bus_arb #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch master
  input  logic        ibus_cyc,
  input  logic        ibus_stb,
  input  logic        ibus_we,
  input  logic [31:0] ibus_adr,
  input  logic [31:0] ibus_dat_o,
  input  logic [3:0]  ibus_sel,
  output logic [31:0] ibus_dat_i,
  output logic        ibus_ack,
  output logic        ibus_stall,
  // load/store master
  input  logic        dbus_cyc,
  input  logic        dbus_stb,
  input  logic        dbus_we,
  input  logic [31:0] dbus_adr,
  input  logic [31:0] dbus_dat_o,
  input  logic [3:0]  dbus_sel,
  output logic [31:0] dbus_dat_i,
  output logic        dbus_ack,
  output logic        dbus_stall,
  // shared memory-side bus
  output logic        mbus_cyc,
  output logic        mbus_stb,
  output logic        mbus_we,
  output logic [31:0] mbus_adr,
  output logic [31:0] mbus_dat_o,
  output logic [3:0]  mbus_sel,
  input  logic [31:0] mbus_dat_i,
  input  logic        mbus_ack,
  input  logic        mbus_stall
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_IBUS = 2'd1, GNT_DBUS = 2'd2} grant_t;
  typedef enum logic {LAST_IBUS = 1'b0, LAST_DBUS = 1'b1} last_t;

  grant_t            grant, grant_nxt;
  last_t             last, last_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              granted, own_cyc, own_stb, full, accept, ack_ok, free;

  // Read data is broadcast; masters qualify it with their own ack.
  assign ibus_dat_i = mbus_dat_i;
  assign dbus_dat_i = mbus_dat_i;

  assign granted  = (grant != GNT_NONE);
  assign full     = (cnt == CNT_W'(MAX_OUTSTANDING));
  // A strobe is only forwarded inside an open cycle and while the window has room.
  assign mbus_stb = own_cyc & own_stb & ~full;
  // Keep the memory-side cycle open until the last outstanding ack is back.
  assign mbus_cyc = granted & (own_cyc | (cnt != '0));
  assign accept   = mbus_stb & ~mbus_stall;
  // Acks with nothing outstanding (or with no owner) are spurious and dropped.
  assign ack_ok   = granted & mbus_ack & (cnt != '0);
  // Arbitrate when idle, or when the owner has closed its cycle and drained.
  assign free     = ~granted | (~own_cyc & (cnt == '0));

  // Grant mux: only the current owner's signals can reach the memory bus.
  always_comb begin
    own_cyc    = 1'b0;
    own_stb    = 1'b0;
    mbus_we    = 1'b0;
    mbus_adr   = '0;
    mbus_dat_o = '0;
    mbus_sel   = '0;
    ibus_ack   = 1'b0;
    ibus_stall = 1'b1;
    dbus_ack   = 1'b0;
    dbus_stall = 1'b1;
    case (grant)
      GNT_IBUS: begin
        own_cyc    = ibus_cyc;
        own_stb    = ibus_stb;
        mbus_we    = ibus_we;
        mbus_adr   = ibus_adr;
        mbus_dat_o = ibus_dat_o;
        mbus_sel   = ibus_sel;
        ibus_ack   = ack_ok;
        ibus_stall = mbus_stall | full;
      end
      GNT_DBUS: begin
        own_cyc    = dbus_cyc;
        own_stb    = dbus_stb;
        mbus_we    = dbus_we;
        mbus_adr   = dbus_adr;
        mbus_dat_o = dbus_dat_o;
        mbus_sel   = dbus_sel;
        dbus_ack   = ack_ok;
        dbus_stall = mbus_stall | full;
      end
      default: ;
    endcase
  end

  // Next grant, round-robin memory and outstanding count.
  always_comb begin
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case ({accept, ack_ok})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
    if (free) begin
      if (ibus_cyc && dbus_cyc) begin
        grant_nxt = (last == LAST_IBUS) ? GNT_DBUS : GNT_IBUS;
      end else if (ibus_cyc) begin
        grant_nxt = GNT_IBUS;
      end else if (dbus_cyc) begin
        grant_nxt = GNT_DBUS;
      end else begin
        grant_nxt = GNT_NONE;
      end
      if (grant_nxt == GNT_IBUS) last_nxt = LAST_IBUS;
      if (grant_nxt == GNT_DBUS) last_nxt = LAST_DBUS;
    end
  end

  // State register; reset drops the bus immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant <= GNT_NONE;
      last  <= LAST_IBUS;
      cnt   <= '0;
    end else begin
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_core_bus_arb.sv
// Testbench for core_bus_arb: directed scenarios with fixed expectations plus
// a randomized run compared against a transaction-level reference model that
// tracks ownership and a queue of issuers of outstanding strobes.
module tb_core_bus_arb;

  localparam int MAXO = 4;

  typedef logic [74:0] ovec_t;
  localparam ovec_t RST_VEC = 75'h5;  // everything 0, both stalls 1

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic = 1'b0, is = 1'b0, iwe = 1'b0;
  logic [31:0] iadr = '0, idat = '0;
  logic [3:0]  isel = '0;
  logic        dc = 1'b0, ds = 1'b0, dwe = 1'b0;
  logic [31:0] dadr = '0, ddat = '0;
  logic [3:0]  dsel = '0;
  logic [31:0] mdat = '0;
  logic        mack = 1'b0, mstall = 1'b0;

  logic [31:0] ibus_dat_i, dbus_dat_i, mbus_adr, mbus_dat_o;
  logic        ibus_ack, ibus_stall, dbus_ack, dbus_stall;
  logic        mbus_cyc, mbus_stb, mbus_we;
  logic [3:0]  mbus_sel;

  int chk = 0;
  int pass = 0;

  // Reference model state: owner 0=none 1=ibus 2=dbus; queue of issuers.
  int m_own = 0;
  int m_last = 1;
  int m_q[$];

  core_bus_arb #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .ibus_cyc(ic), .ibus_stb(is), .ibus_we(iwe), .ibus_adr(iadr), .ibus_dat_o(idat),
    .ibus_sel(isel), .ibus_dat_i(ibus_dat_i), .ibus_ack(ibus_ack), .ibus_stall(ibus_stall),
    .dbus_cyc(dc), .dbus_stb(ds), .dbus_we(dwe), .dbus_adr(dadr), .dbus_dat_o(ddat),
    .dbus_sel(dsel), .dbus_dat_i(dbus_dat_i), .dbus_ack(dbus_ack), .dbus_stall(dbus_stall),
    .mbus_cyc(mbus_cyc), .mbus_stb(mbus_stb), .mbus_we(mbus_we), .mbus_adr(mbus_adr),
    .mbus_dat_o(mbus_dat_o), .mbus_sel(mbus_sel), .mbus_dat_i(mdat), .mbus_ack(mack),
    .mbus_stall(mstall)
  );

  always #5 clk = ~clk;

  function automatic ovec_t obs_vec();
    return {mbus_cyc, mbus_stb, mbus_we, mbus_adr, mbus_dat_o, mbus_sel,
            ibus_ack, ibus_stall, dbus_ack, dbus_stall};
  endfunction

  // Expected outputs from the model state and the current inputs.
  function automatic ovec_t exp_vec();
    logic c, s, w, ia, ist, da, dst;
    logic [31:0] a, d;
    logic [3:0] sl;
    bit full;
    c = 0; s = 0; w = 0; a = '0; d = '0; sl = '0; ia = 0; da = 0; ist = 1; dst = 1;
    if (rst && m_own != 0) begin
      full = (m_q.size() >= MAXO);
      if (m_own == 1) begin c = ic; s = is; w = iwe; a = iadr; d = idat; sl = isel; end
      else            begin c = dc; s = ds; w = dwe; a = dadr; d = ddat; sl = dsel; end
      s = c & s & !full;
      c = c | (m_q.size() > 0);
      if (m_own == 1) ist = mstall | full; else dst = mstall | full;
    end
    if (rst && mack && m_q.size() > 0) begin
      if (m_q[0] == 1) ia = 1; else da = 1;
    end
    return {c, s, w, a, d, sl, ia, ist, da, dst};
  endfunction

  // Advance the model by one clock edge.
  task automatic model_step();
    int sz;
    bit oc, os;
    sz = m_q.size();
    oc = 0; os = 0;
    if (m_own != 0) begin
      oc = (m_own == 1) ? ic : dc;
      os = (m_own == 1) ? is : ds;
      if (mack && sz > 0) void'(m_q.pop_front());
      if (oc && os && sz < MAXO && !mstall) m_q.push_back(m_own);
    end
    if (m_own == 0 || (!oc && sz == 0)) begin
      if (ic && dc)  m_own = (m_last == 1) ? 2 : 1;
      else if (ic)   m_own = 1;
      else if (dc)   m_own = 2;
      else           m_own = 0;
      if (m_own != 0) m_last = m_own;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_own = 0; m_last = 1; m_q.delete();
      end else if (clk) begin
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic = 0; is = 0; dc = 0; ds = 0; mack = 0; mstall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic test_reset();
    ic = 1; dc = 1; mack = 1; is = 1; ds = 1; iadr = 32'h11; dadr = 32'h22;
    #3;
    chk++; if (obs_vec() !== RST_VEC) $display("FAIL reset_async: got %h want %h", obs_vec(), RST_VEC); else pass++;
    tick();
    chk++; if (obs_vec() !== RST_VEC) $display("FAIL reset_clocked: got %h want %h", obs_vec(), RST_VEC); else pass++;
    idle_inputs();
    #2 rst = 1;
  endtask

  task automatic test_single();
    do_reset();
    tick(); ic = 1; is = 1; iadr = 32'h100; isel = 4'hf; #1;
    chk++; if (ibus_stall !== 1'b1 || mbus_cyc !== 1'b0) $display("FAIL single_latency: stall %b cyc %b want 1 0", ibus_stall, mbus_cyc); else pass++;
    tick();
    chk++; if (mbus_stb !== 1'b1 || mbus_adr !== 32'h100) $display("FAIL single_stb: stb %b adr %h want 1 100", mbus_stb, mbus_adr); else pass++;
    chk++; if (dbus_stall !== 1'b1 || dbus_ack !== 1'b0) $display("FAIL single_nonowner: stall %b ack %b want 1 0", dbus_stall, dbus_ack); else pass++;
    tick(); is = 0; mack = 1; mdat = 32'hcafef00d; #1;
    chk++; if (ibus_ack !== 1'b1 || ibus_dat_i !== 32'hcafef00d) $display("FAIL single_ack: ack %b dat %h want 1 cafef00d", ibus_ack, ibus_dat_i); else pass++;
    chk++; if (dbus_ack !== 1'b0 || dbus_stall !== 1'b1) $display("FAIL single_ack_other: ack %b stall %b want 0 1", dbus_ack, dbus_stall); else pass++;
    tick(); mack = 0; ic = 0; #1;
    chk++; if (mbus_cyc !== 1'b0) $display("FAIL single_close: cyc %b want 0", mbus_cyc); else pass++;
    tick(); tick();
  endtask

  task automatic test_tie();
    do_reset();
    tick(); ic = 1; dc = 1; iadr = 32'h200; dadr = 32'h300;
    tick();
    chk++; if (mbus_adr !== 32'h300 || dbus_stall !== 1'b0 || ibus_stall !== 1'b1) $display("FAIL tie_first: adr %h dstall %b istall %b want 300 0 1", mbus_adr, dbus_stall, ibus_stall); else pass++;
    dc = 0;
    tick();
    chk++; if (mbus_adr !== 32'h200 || mbus_cyc !== 1'b1 || ibus_stall !== 1'b0) $display("FAIL tie_handover: adr %h cyc %b istall %b want 200 1 0", mbus_adr, mbus_cyc, ibus_stall); else pass++;
    ic = 0;
    tick();
    ic = 1; dc = 1;
    tick(); tick();
    chk++; if (mbus_adr !== 32'h300 || dbus_stall !== 1'b0) $display("FAIL tie_second: adr %h dstall %b want 300 0", mbus_adr, dbus_stall); else pass++;
    ic = 0; dc = 0;
    tick(); tick();
  endtask

  task automatic test_pipeline_limit();
    int accepts;
    accepts = 0;
    do_reset();
    tick(); ic = 1; is = 1; iadr = 32'h400;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk++; if (mbus_stb !== (k <= 4) || ibus_stall !== (k >= 5)) $display("FAIL limit_cycle%0d: stb %b stall %b want %b %b", k, mbus_stb, ibus_stall, k <= 4, k >= 5); else pass++;
      if (mbus_stb && !mstall) accepts++;
    end
    chk++; if (accepts != 4) $display("FAIL limit_accepts: got %0d want 4", accepts); else pass++;
    tick(); mack = 1; #1;
    chk++; if (ibus_ack !== 1'b1 || mbus_stb !== 1'b0) $display("FAIL limit_ack: ack %b stb %b want 1 0", ibus_ack, mbus_stb); else pass++;
    tick(); mack = 0; #1;
    chk++; if (mbus_stb !== 1'b1 || ibus_stall !== 1'b0) $display("FAIL limit_reopen: stb %b stall %b want 1 0", mbus_stb, ibus_stall); else pass++;
    tick();
    chk++; if (ibus_stall !== 1'b1) $display("FAIL limit_refull: stall %b want 1", ibus_stall); else pass++;
    is = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); mack = 1;
    end
    tick(); mack = 0; ic = 0; #1;
    chk++; if (mbus_cyc !== 1'b0) $display("FAIL limit_drain: cyc %b want 0", mbus_cyc); else pass++;
    tick(); tick();
  endtask

  task automatic test_early_drop();
    do_reset();
    tick(); dc = 1; ds = 1; dadr = 32'h500; iadr = 32'h600;
    tick(); tick();
    tick(); dc = 0; ds = 0; ic = 1; #1;
    chk++; if (mbus_cyc !== 1'b1 || mbus_adr !== 32'h500 || ibus_stall !== 1'b1) $display("FAIL drop_hold: cyc %b adr %h istall %b want 1 500 1", mbus_cyc, mbus_adr, ibus_stall); else pass++;
    tick(); mack = 1; #1;
    chk++; if (dbus_ack !== 1'b1 || ibus_ack !== 1'b0) $display("FAIL drop_ack1: dack %b iack %b want 1 0", dbus_ack, ibus_ack); else pass++;
    tick();
    chk++; if (dbus_ack !== 1'b1 || ibus_ack !== 1'b0) $display("FAIL drop_ack2: dack %b iack %b want 1 0", dbus_ack, ibus_ack); else pass++;
    tick(); mack = 0; #1;
    chk++; if (ibus_stall !== 1'b1 || mbus_cyc !== 1'b0) $display("FAIL drop_drained: istall %b cyc %b want 1 0", ibus_stall, mbus_cyc); else pass++;
    tick();
    chk++; if (ibus_stall !== 1'b0 || mbus_adr !== 32'h600) $display("FAIL drop_handover: istall %b adr %h want 0 600", ibus_stall, mbus_adr); else pass++;
    ic = 0;
    tick(); tick();
  endtask

  task automatic test_simul_ack();
    do_reset();
    tick(); ic = 1; is = 1;
    tick(); tick(); tick();
    tick(); mack = 1; #1;
    chk++; if (ibus_ack !== 1'b1 || mbus_stb !== 1'b1) $display("FAIL simul_both: ack %b stb %b want 1 1", ibus_ack, mbus_stb); else pass++;
    tick(); mack = 0; #1;
    chk++; if (ibus_stall !== 1'b0) $display("FAIL simul_cnt3: stall %b want 0", ibus_stall); else pass++;
    tick();
    chk++; if (ibus_stall !== 1'b1) $display("FAIL simul_cnt4: stall %b want 1", ibus_stall); else pass++;
    is = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); mack = 1;
    end
    tick(); mack = 0; ic = 0;
    tick(); tick(); mack = 1; #1;
    chk++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL spurious_ack: iack %b dack %b want 0 0", ibus_ack, dbus_ack); else pass++;
    tick(); mack = 0; ic = 1;
    tick(); ic = 0; #1;
    chk++; if (mbus_cyc !== 1'b0) $display("FAIL spurious_cnt: cyc %b want 0", mbus_cyc); else pass++;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); ic = 1; is = 1;
    tick(); tick();
    tick(); is = 0; #1;
    chk++; if (mbus_cyc !== 1'b1) $display("FAIL areset_pre: cyc %b want 1", mbus_cyc); else pass++;
    #2 rst = 0;
    #1;
    chk++; if (mbus_cyc !== 1'b0 || ibus_stall !== 1'b1 || dbus_stall !== 1'b1) $display("FAIL areset_immediate: cyc %b istall %b dstall %b want 0 1 1", mbus_cyc, ibus_stall, dbus_stall); else pass++;
    ic = 0;
    @(posedge clk); #2 rst = 1;
    tick(); mack = 1; #1;
    chk++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL areset_late1: iack %b dack %b want 0 0", ibus_ack, dbus_ack); else pass++;
    tick();
    chk++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) $display("FAIL areset_late2: iack %b dack %b want 0 0", ibus_ack, dbus_ack); else pass++;
    tick(); mack = 0; #1;
    chk++; if (mbus_cyc !== 1'b0 || ibus_stall !== 1'b1) $display("FAIL areset_idle: cyc %b istall %b want 0 1", mbus_cyc, ibus_stall); else pass++;
    ic = 1;
    tick(); ic = 0; #1;
    chk++; if (mbus_cyc !== 1'b0) $display("FAIL areset_cnt: cyc %b want 0", mbus_cyc); else pass++;
    tick(); tick();
  endtask

  task automatic test_random();
    ovec_t e;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      tick();
      if ($urandom_range(7) == 0) ic = ~ic;
      if ($urandom_range(7) == 0) dc = ~dc;
      is = ic & 1'($urandom_range(1));
      ds = dc & 1'($urandom_range(1));
      iwe = 1'($urandom_range(1)); iadr = $urandom; idat = $urandom; isel = 4'($urandom_range(15));
      dwe = 1'($urandom_range(1)); dadr = $urandom; ddat = $urandom; dsel = 4'($urandom_range(15));
      mstall = ($urandom_range(3) == 0);
      mack = ($urandom_range(2) == 0);
      mdat = $urandom;
      #1;
      e = exp_vec();
      chk++; if (obs_vec() !== e) $display("FAIL random_outputs cycle %0d: got %h want %h", n, obs_vec(), e); else pass++;
      chk++; if (ibus_dat_i !== mdat || dbus_dat_i !== mdat) $display("FAIL random_dat_i cycle %0d: got %h %h want %h", n, ibus_dat_i, dbus_dat_i, mdat); else pass++;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_pipeline_limit();
    test_early_drop();
    test_simul_ack();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
